// File: rtl/oflow_pe_set_scheduler.sv
// Set scheduler: splits a frame's bboxes into PE_NUM-sized sets and
// launches the PE array once per DMA-delivered feature set.
module oflow_pe_set_scheduler #(
    parameter int PE_NUM = 24,
    parameter int BBOX_W = 7,
    parameter int SET_W  = 3
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              start,
    input  logic [BBOX_W-1:0] num_of_bbox_in_frame,
    input  logic              abort,
    input  logic              new_set,
    output logic              ready_new_set,
    output logic              pe_start,
    output logic [PE_NUM-1:0] pe_en_mask,
    output logic [SET_W-1:0]  set_idx,
    input  logic              pe_done,
    output logic              done_pe,
    output logic              busy,
    output logic [SET_W-1:0]  num_of_sets,
    output logic [BBOX_W-1:0] counter_of_remain_bboxes
);
    typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_e;

    localparam int NW = BBOX_W + 1;
    localparam logic [BBOX_W-1:0] PE_CNT = BBOX_W'(PE_NUM);

    state_e            state_q, state_d;
    logic [SET_W-1:0]  sets_q, sets_d;
    logic [SET_W-1:0]  idx_q, idx_d;
    logic [BBOX_W-1:0] remain_q, remain_d;
    logic              pe_start_q, pe_start_d;
    logic [BBOX_W-1:0] chunk;
    logic [NW-1:0]     sets_ceil;

    assign chunk     = (remain_q > PE_CNT) ? PE_CNT : remain_q;
    assign sets_ceil = ({1'b0, num_of_bbox_in_frame} + NW'(PE_NUM - 1))
                       / NW'(PE_NUM);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= IDLE;
            sets_q     <= '0;
            idx_q      <= '0;
            remain_q   <= '0;
            pe_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sets_q     <= sets_d;
            idx_q      <= idx_d;
            remain_q   <= remain_d;
            pe_start_q <= pe_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sets_d     = sets_q;
        idx_d      = idx_q;
        remain_d   = remain_q;
        pe_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sets_d   = SET_W'(sets_ceil);
                    remain_d = num_of_bbox_in_frame;
                    idx_d    = '0;
                    state_d  = (num_of_bbox_in_frame != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (abort) begin
                    state_d  = IDLE;
                    remain_d = '0;
                    idx_d    = '0;
                end else if (new_set) begin
                    state_d    = RUN;
                    pe_start_d = 1'b1;
                end
            end
            RUN: begin
                // A completion coincident with the launch pulse is stale.
                if (abort) begin
                    state_d  = IDLE;
                    remain_d = '0;
                    idx_d    = '0;
                end else if (pe_done && !pe_start_q) begin
                    remain_d = remain_q - chunk;
                    idx_d    = idx_q + 1'b1;
                    state_d  = (remain_q == chunk) ? DONE : REQ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_new_set = (state_q == REQ);
        busy          = (state_q != IDLE);
        done_pe       = (state_q == DONE);
        pe_en_mask    = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < PE_NUM; i++) begin
                pe_en_mask[i] = (int'(remain_q) > i);
            end
        end
    end

    assign pe_start                 = pe_start_q;
    assign set_idx                  = idx_q;
    assign num_of_sets              = sets_q;
    assign counter_of_remain_bboxes = remain_q;

endmodule

// File: tb/tb_oflow_pe_set_scheduler.sv
// Bench for oflow_pe_set_scheduler: directed frames plus a random
// phase, all checked cycle by cycle against a behavioural model.
module tb_oflow_pe_set_scheduler;
    localparam int PE = 24;
    localparam int BW = 7;
    localparam int SW = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_WORK = 2;
    localparam int PH_FIN  = 3;

    logic          clk = 1'b0;
    logic          reset_N = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          new_set = 1'b0;
    logic          pe_done = 1'b0;
    logic [BW-1:0] nbb = '0;

    logic          ready_new_set;
    logic          pe_start;
    logic [PE-1:0] pe_en_mask;
    logic [SW-1:0] set_idx;
    logic          done_pe;
    logic          busy;
    logic [SW-1:0] num_of_sets;
    logic [BW-1:0] remain;

    int checks = 0;
    int failures = 0;

    int m_ph, m_rem, m_idx, m_sets;
    bit m_first;

    oflow_pe_set_scheduler #(
        .PE_NUM(PE), .BBOX_W(BW), .SET_W(SW)
    ) dut (
        .clk                     (clk),
        .reset_N                 (reset_N),
        .start                   (start),
        .num_of_bbox_in_frame    (nbb),
        .abort                   (abort),
        .new_set                 (new_set),
        .ready_new_set           (ready_new_set),
        .pe_start                (pe_start),
        .pe_en_mask              (pe_en_mask),
        .set_idx                 (set_idx),
        .pe_done                 (pe_done),
        .done_pe                 (done_pe),
        .busy                    (busy),
        .num_of_sets             (num_of_sets),
        .counter_of_remain_bboxes(remain)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ph = PH_IDLE;
        m_rem = 0;
        m_idx = 0;
        m_sets = 0;
        m_first = 0;
    endfunction

    // Frame bookkeeping from the rules: ceil sets, min(rem,PE) per set.
    function automatic void model_step();
        bit launched = m_first;
        int n;
        m_first = 0;
        if (m_ph == PH_IDLE) begin
            if (start) begin
                m_sets = (int'(nbb) + PE - 1) / PE;
                m_rem = int'(nbb);
                m_idx = 0;
                m_ph = (nbb == 0) ? PH_FIN : PH_WAIT;
            end
        end else if (m_ph == PH_FIN) begin
            m_ph = PH_IDLE;
        end else if (abort) begin
            m_ph = PH_IDLE;
            m_rem = 0;
            m_idx = 0;
        end else if (m_ph == PH_WAIT) begin
            if (new_set) begin
                m_ph = PH_WORK;
                m_first = 1;
            end
        end else if (pe_done && !launched) begin
            n = (m_rem < PE) ? m_rem : PE;
            m_rem = m_rem - n;
            m_idx = m_idx + 1;
            m_ph = (m_rem == 0) ? PH_FIN : PH_WAIT;
        end
    endfunction

    task automatic check_all(string t);
        int n = (m_rem < PE) ? m_rem : PE;
        logic [31:0] em;
        em = (m_ph == PH_WORK) ? ((32'd1 << n) - 32'd1) : 32'd0;
        chk({t, ".ready"}, 32'(ready_new_set), 32'(m_ph == PH_WAIT));
        chk({t, ".pe_start"}, 32'(pe_start), 32'(m_first));
        chk({t, ".mask"}, 32'(pe_en_mask), em);
        chk({t, ".set_idx"}, 32'(set_idx), 32'(m_idx));
        chk({t, ".done_pe"}, 32'(done_pe), 32'(m_ph == PH_FIN));
        chk({t, ".busy"}, 32'(busy), 32'(m_ph != PH_IDLE));
        chk({t, ".sets"}, 32'(num_of_sets), 32'(m_sets));
        chk({t, ".remain"}, 32'(remain), 32'(m_rem));
    endtask

    task automatic step(string t);
        @(posedge clk);
        model_step();
        #1;
        check_all(t);
        start = 1'b0;
        abort = 1'b0;
        new_set = 1'b0;
        pe_done = 1'b0;
    endtask

    task automatic begin_frame(int n, string t);
        start = 1'b1;
        nbb = BW'(n);
        step(t);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("rst0");
        @(negedge clk);
        reset_N = 1'b1;
        step("idle0");

        // N=50: three sets of 24, 24, 2
        begin_frame(50, "n50.start");
        chk("n50.sets_const", 32'(num_of_sets), 32'd3);
        chk("n50.rem_const0", 32'(remain), 32'd50);
        step("n50.gap");
        new_set = 1'b1;
        step("n50.run0");
        chk("n50.mask0", 32'(pe_en_mask), 32'hFFFFFF);
        chk("n50.idx0", 32'(set_idx), 32'd0);
        pe_done = 1'b1;
        step("n50.stale_done");
        pe_done = 1'b1;
        step("n50.done0");
        chk("n50.rem_const1", 32'(remain), 32'd26);
        new_set = 1'b1;
        step("n50.run1");
        chk("n50.mask1", 32'(pe_en_mask), 32'hFFFFFF);
        chk("n50.idx1", 32'(set_idx), 32'd1);
        step("n50.hold1");
        pe_done = 1'b1;
        step("n50.done1");
        chk("n50.rem_const2", 32'(remain), 32'd2);
        new_set = 1'b1;
        step("n50.run2");
        chk("n50.mask2", 32'(pe_en_mask), 32'h000003);
        chk("n50.idx2", 32'(set_idx), 32'd2);
        step("n50.hold2");
        pe_done = 1'b1;
        step("n50.done2");
        chk("n50.done_pe", 32'(done_pe), 32'd1);
        chk("n50.rem_const3", 32'(remain), 32'd0);
        abort = 1'b1;
        step("n50.idle");

        // N=24: exactly one full set
        begin_frame(24, "n24.start");
        chk("n24.sets_const", 32'(num_of_sets), 32'd1);
        new_set = 1'b1;
        step("n24.run");
        chk("n24.mask", 32'(pe_en_mask), 32'hFFFFFF);
        step("n24.hold");
        pe_done = 1'b1;
        step("n24.done");
        chk("n24.done_pe", 32'(done_pe), 32'd1);
        step("n24.idle");

        // N=0: straight to DONE
        begin_frame(0, "n0.start");
        chk("n0.done_pe", 32'(done_pe), 32'd1);
        chk("n0.ready", 32'(ready_new_set), 32'd0);
        step("n0.idle");
        chk("n0.busy", 32'(busy), 32'd0);

        // N=30: abort with pe_done during set 0
        begin_frame(30, "n30.start");
        new_set = 1'b1;
        step("n30.run");
        step("n30.hold");
        abort = 1'b1;
        pe_done = 1'b1;
        step("n30.abort");
        chk("n30.busy", 32'(busy), 32'd0);
        chk("n30.rem", 32'(remain), 32'd0);
        step("n30.after");
        chk("n30.no_done", 32'(done_pe), 32'd0);

        // Ignored inputs in the wrong state
        begin_frame(50, "ign.start");
        pe_done = 1'b1;
        step("ign.done_in_req");
        new_set = 1'b1;
        step("ign.run");
        step("ign.settle");
        start = 1'b1;
        nbb = 7'd10;
        step("ign.start_in_run");
        new_set = 1'b1;
        step("ign.newset_in_run");
        chk("ign.mask", 32'(pe_en_mask), 32'hFFFFFF);
        chk("ign.rem", 32'(remain), 32'd50);

        // Reset mid-RUN discards the frame
        #2;
        reset_N = 1'b0;
        #1;
        model_reset();
        check_all("rst.mid");
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.mask", 32'(pe_en_mask), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_N = 1'b1;
        step("rst.quiet0");
        step("rst.quiet1");
        begin_frame(10, "n10.start");
        new_set = 1'b1;
        step("n10.run");
        chk("n10.mask", 32'(pe_en_mask), 32'h0003FF);
        step("n10.hold");
        pe_done = 1'b1;
        step("n10.done");
        step("n10.idle");

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 9) == 0);
            nbb = BW'($urandom_range(0, 127));
            new_set = ($urandom_range(0, 2) == 0);
            pe_done = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 39) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oflow_pe_set_scheduler.md
OFLOW_PE_SET_SCHEDULER -- requirements
Module: oflow_pe_set_scheduler

Interface
REQ-001 Parameter PE_NUM, default 24: number of PEs in the array, and the maximum number of bboxes per set.
REQ-002 Parameter BBOX_W, default 7: width of the bbox counts; a frame holds at most 127 bboxes.
REQ-003 Parameter SET_W, default 3: width of the set index and set count.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle pulse from the core FSM that begins a frame.
REQ-007 Port num_of_bbox_in_frame, input, BBOX_W bits: bbox count, sampled only on an accepted start.
REQ-008 Port abort, input, 1 bit: pulse that cancels the frame in progress (conflict threshold hit).
REQ-009 Port new_set, input, 1 bit: DMA pulse indicating the next feature set is ready.
REQ-010 Port ready_new_set, output, 1 bit: the scheduler is waiting for a set from the DMA.
REQ-011 Port pe_start, output, 1 bit: one-cycle pulse that launches the PE array on the current set.
REQ-012 Port pe_en_mask, output, PE_NUM bits: bit i enables PE i for the current set.
REQ-013 Port set_idx, output, SET_W bits: zero-based index of the current set.
REQ-014 Port pe_done, input, 1 bit: pulse from the PE array indicating the current set is complete.
REQ-015 Port done_pe, output, 1 bit: one-cycle pulse indicating all sets of the frame are processed.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port num_of_sets, output, SET_W bits: ceil(num_of_bbox_in_frame / PE_NUM), latched at start.
REQ-018 Port counter_of_remain_bboxes, output, BBOX_W bits: bboxes not yet dispatched to the PEs.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, REQ, RUN and DONE.
REQ-020 IDLE: start=1 SHALL latch num_of_sets and counter_of_remain_bboxes, and clear set_idx.
- Next state is REQ if the count is nonzero, otherwise DONE.
REQ-021 ready_new_set SHALL equal (state==REQ), decoded combinationally from the state register.
REQ-022 REQ: new_set=1 SHALL move the FSM to RUN, with pe_start=1 during exactly the first RUN cycle (registered).
REQ-023 pe_en_mask SHALL have its low min(counter_of_remain_bboxes, PE_NUM) bits set and all other bits zero.
- It is valid while in RUN, held stable for the whole RUN state, and zero outside RUN.
REQ-024 RUN with pe_done=1 SHALL:
- subtract min(counter_of_remain_bboxes, PE_NUM) from counter_of_remain_bboxes;
- increment set_idx;
- go to DONE if the remainder becomes 0, otherwise go to REQ.
REQ-025 DONE SHALL assert done_pe for exactly one cycle, then return to IDLE.
REQ-026 pe_done SHALL be ignored at the rising edge where pe_start is high.
REQ-027 pe_done SHALL be ignored outside RUN.
REQ-028 new_set SHALL be ignored outside REQ; a dropped pulse is not queued.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in REQ or RUN SHALL:
- return the FSM to IDLE on the next edge;
- suppress done_pe;
- clear counter_of_remain_bboxes and set_idx.
REQ-031 abort SHALL take priority over a simultaneous new_set or pe_done.
REQ-032 abort SHALL be ignored in IDLE and DONE.
REQ-033 Counter subtraction SHALL never underflow; the last set dispatches only the remainder.
REQ-034 set_idx SHALL never exceed num_of_sets-1 while in RUN.

Reset
REQ-035 reset_N=0 SHALL immediately force the FSM to IDLE, regardless of clk.
REQ-036 In reset, all outputs SHALL be 0: ready_new_set, pe_start, pe_en_mask, set_idx, done_pe, busy, num_of_sets and counter_of_remain_bboxes.
REQ-037 Reset asserted mid-frame SHALL discard all progress; after release, nothing happens until a new start.

Verification
REQ-038 N=50, three new_set/pe_done handshakes -> the bench SHALL see:
- num_of_sets=3;
- masks 0xFFFFFF, 0xFFFFFF, 0x000003;
- set_idx 0, 1, 2;
- remain 50 -> 26 -> 2 -> 0;
- done_pe one cycle after the third pe_done.
REQ-039 N=24 -> the bench SHALL see one set, mask 0xFFFFFF, num_of_sets=1, and done_pe after the first pe_done.
REQ-040 N=0 -> the bench SHALL see IDLE -> DONE -> IDLE, done_pe on cycle 1 after start, and ready_new_set and pe_start never asserted.
REQ-041 N=30, abort pulsed together with pe_done during set 0 -> the bench SHALL see IDLE next cycle, no done_pe, and remain=0.
REQ-042 Start pulse during RUN, new_set during RUN, pe_done during REQ -> the bench SHALL see all three ignored with state, counters and mask unchanged.
REQ-043 reset_N pulsed low mid-RUN at N=50, then start with N=10 -> the bench SHALL see:
- all outputs 0 during reset;
- a clean new frame with mask 0x0003FF.
